switch_led_ctrl: RTL
====================

SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of switch/LED channels, legal range 2..32.
REQ-002 Parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a switch change, legal range 2..65535.
REQ-003 Parameter TICK_DIV, default 1000000: clk cycles per display tick, legal range 2..2^24.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port switch  input  WIDTH: raw asynchronous switch levels.
REQ-007 Port mode  input  2: display mode select, 00 direct, 01 blink, 10 chase, 11 invert.
REQ-008 Port led  output  WIDTH: registered LED drive.
REQ-009 Port sw_stable  output  WIDTH: registered debounced switch state.
REQ-010 Port sw_change  output  1: one-cycle pulse when any sw_stable bit changes.

Function
REQ-011 Each switch bit passes a 2-flop synchronizer; the synchronized value is sync[i].
REQ-012 Each bit has a counter; while sync[i] equals sw_stable[i], the counter holds 0.
REQ-013 While sync[i] differs from sw_stable[i], the counter increments once per cycle; in the cycle it would reach DEB_CYCLES, sw_stable[i] takes sync[i] and the counter returns to 0.
REQ-014 Any cycle where sync[i] returns to sw_stable[i] before acceptance clears that bit's counter (glitch rejected).
REQ-015 Latency: a clean switch edge at cycle 0 appears on sw_stable at cycle 2+DEB_CYCLES and on led (direct mode) one cycle later.
REQ-016 sw_change is high for exactly the one cycle following any sw_stable update; simultaneous updates on several bits produce one pulse.
REQ-017 A prescaler counts 0..TICK_DIV-1 and wraps; tick is high in the wrap cycle only.
REQ-018 blink_phase toggles on every tick; the chase register rotates left by one on every tick, bit WIDTH-1 wrapping to bit 0.
REQ-019 mode is registered; led next = sw_stable (00), sw_stable AND {WIDTH{blink_phase}} (01), chase register (10), NOT sw_stable (11).
REQ-020 A mode change takes effect on led two cycles after the mode input changes; prescaler, blink_phase and chase register keep running across mode changes.
REQ-021 Prescaler, blink_phase and chase register advance regardless of mode and switch activity.

Reset
REQ-022 Asserting rst forces immediately: led = only bit WIDTH-1 set, sw_stable = 0, sw_change = 0, synchronizers = 0, debounce counters = 0.
REQ-023 Asserting rst forces: prescaler = 0, blink_phase = 0, chase register = only bit WIDTH-1 set, registered mode = 00.
REQ-024 Reset asserted mid-debounce or mid-tick discards all progress; after release the first tick occurs TICK_DIV cycles later.
REQ-025 led holds its reset value until the first post-reset sw_stable or mode update propagates.

Configuration
REQ-026 Macro SWITCH_LED_DEBOUNCE_EN defined: debounce counters present, behaviour per REQ-012..REQ-015.
REQ-027 Macro SWITCH_LED_DEBOUNCE_EN undefined: no counters; sw_stable = sync registered one cycle (edge to sw_stable at cycle 3); DEB_CYCLES ignored; sw_change and all other behaviour unchanged.

Verification (WIDTH=8, DEB_CYCLES=4, TICK_DIV=4, macro defined unless stated)
REQ-028 rst pulse mid-run -> led=0x80, sw_stable=0x00, sw_change=0 within the same cycle, held while rst=1.
REQ-029 mode=00, switch 0x00->0x3C at cycle 0 -> sw_stable=0x3C at cycle 6, sw_change pulse at cycle 7, led=0x3C at cycle 7.
REQ-030 switch bit 0 high for 3 cycles then low -> sw_stable stays 0x00, no sw_change pulse.
REQ-031 mode=10 after reset -> led steps 0x80,0x01,0x02,0x04 on successive ticks, 4 cycles apart.
REQ-032 mode=01, sw_stable=0xFF -> led alternates 0x00/0xFF every 4 cycles; mode=11 with sw_stable=0x0F -> led=0xF0.
REQ-033 Macro undefined, switch 0x00->0x01 at cycle 0 -> sw_stable=0x01 at cycle 3, 1-cycle glitches passed through.

Source files
------------

// File: rtl/switch_led_ctrl.sv
// Switch debouncer and LED display controller with direct/blink/chase/invert modes.
// Define SWITCH_LED_DEBOUNCE_EN to enable per-bit debounce counters; otherwise sw_stable is sync delayed one cycle.

module switch_led_ctrl_bit #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable
);
    logic s1, s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

`ifdef SWITCH_LED_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronized level disagrees; any agreement clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stable <= 1'b0;
        else     stable <= s2;
    end
`endif
endmodule

module switch_led_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int TICK_DIV   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_change
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] chase;
    logic [WIDTH-1:0] led_nxt;
    logic [PW-1:0]    presc;
    logic [1:0]       mode_q, mode_d;
    logic             tick, blink_phase, hold, upd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_led_ctrl_bit #(.DEB_CYCLES(DEB_CYCLES)) u_bit (
            .clk    (clk),
            .rst    (rst),
            .sw     (switch[i]),
            .stable (sw_stable[i])
        );
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            blink_phase <= 1'b0;
            chase       <= TOP_BIT;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                blink_phase <= ~blink_phase;
                chase       <= {chase[WIDTH-2:0], chase[WIDTH-1]};
            end
        end
    end

    // upd flags a registered switch-state or mode update visible this cycle;
    // the reset LED pattern is held until the first one arrives.
    assign upd = (sw_stable != stable_q) || (mode_q != mode_d);

    always_comb begin
        led_nxt = sw_stable;
        case (mode_q)
            2'b00: led_nxt = sw_stable;
            2'b01: led_nxt = sw_stable & {WIDTH{blink_phase}};
            2'b10: led_nxt = chase;
            2'b11: led_nxt = ~sw_stable;
            default: led_nxt = sw_stable;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q  <= '0;
            sw_change <= 1'b0;
            mode_q    <= 2'b00;
            mode_d    <= 2'b00;
            hold      <= 1'b1;
            led       <= TOP_BIT;
        end else begin
            stable_q  <= sw_stable;
            sw_change <= (sw_stable != stable_q);
            mode_q    <= mode;
            mode_d    <= mode_q;
            hold      <= hold && !upd;
            if (!hold || upd) led <= led_nxt;
        end
    end
endmodule
